// File: rtl/ram_ctrl_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
// Holds the controller FSM state type and the round-robin pick function.
package ram_ctrl_pkg;

    localparam int unsigned DefAddrWidth = 16;
    localparam int unsigned DefDataWidth = 8;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAccess  = 2'd1,
        StCapture = 2'd2
    } state_e;

    // prio = 1 favours requester 1 when both request; a lone requester always wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic prio);
        logic [1:0] gnt;
        if (req == 2'b11) begin
            gnt = prio ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a registered priority pointer.
// The pointer only moves when the controller accepts the offered grant.
module rr_arb2
    import ram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt = rr_pick(req, prio_q);
    end

    // After granting requester 0, favour requester 1 next time, and vice versa.
    always_comb begin
        prio_d = prio_q;
        if (accept && (gnt != 2'b00)) begin
            prio_d = gnt[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one asynchronous SRAM port between two requesters.
// Writes take IDLE->ACCESS, reads IDLE->ACCESS->CAPTURE; done pulses back in IDLE.
module ram_port_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned DATA_WIDTH = DefDataWidth
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  done0,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  ram_drive,
    input  logic [DATA_WIDTH-1:0] ram_din
);

    state_e                state_q;
    state_e                state_d;
    logic [1:0]            arb_gnt;
    logic                  accept;
    logic                  finish;
    logic                  owner_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [1:0]            done_q;
    logic [1:0]            done_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({req1, req0}),
        .accept (accept),
        .gnt    (arb_gnt)
    );

    assign accept = (state_q == StIdle) && (arb_gnt != 2'b00);
    assign finish = ((state_q == StAccess) && we_q) || (state_q == StCapture);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (req0 || req1) state_d = StAccess;
            StAccess:  state_d = we_q ? StIdle : StCapture;
            StCapture: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output logic; gnt is gated by rst_n so it reads 0 while reset is held.
    always_comb begin
        gnt0      = rst_n && (state_q == StIdle) && arb_gnt[0];
        gnt1      = rst_n && (state_q == StIdle) && arb_gnt[1];
        ram_cs    = 1'b0;
        ram_we    = 1'b0;
        ram_oe    = 1'b0;
        ram_drive = 1'b0;
        ram_addr  = '0;
        ram_dout  = '0;
        unique case (state_q)
            StAccess: begin
                ram_cs    = 1'b1;
                ram_addr  = addr_q;
                ram_we    = we_q;
                ram_oe    = !we_q;
                ram_drive = we_q;
                if (we_q) ram_dout = wdata_q;
            end
            StCapture: begin
                ram_cs   = 1'b1;
                ram_addr = addr_q;
                ram_oe   = 1'b1;
            end
            default: ;
        endcase
    end

    // Command latch: only written on the grant edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            owner_q <= arb_gnt[1];
            we_q    <= arb_gnt[1] ? we1 : we0;
            addr_q  <= arb_gnt[1] ? addr1 : addr0;
            wdata_q <= arb_gnt[1] ? wdata1 : wdata0;
        end
    end

    always_comb begin
        done_d = {owner_q, !owner_q} & {2{finish}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q  <= 2'b00;
            rdata_q <= '0;
        end else begin
            done_q <= done_d;
            if (state_q == StCapture) rdata_q <= ram_din;
        end
    end

    assign done0 = done_q[0];
    assign done1 = done_q[1];
    assign rdata = rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural SRAM and
// per-requester scoreboards of expected completions.
module tb_ram_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, done0, done1;
    logic [DW-1:0] rdata;
    logic          ram_cs, ram_we, ram_oe, ram_drive;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout, ram_din;

    logic [DW-1:0] mem [2**AW];

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .rdata     (rdata),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_oe    (ram_oe),
        .ram_addr  (ram_addr),
        .ram_dout  (ram_dout),
        .ram_drive (ram_drive),
        .ram_din   (ram_din)
    );

    // Asynchronous-read SRAM, written on the clock edge while driven.
    always @(posedge clk) if (ram_cs && ram_we && ram_drive) mem[ram_addr] <= ram_dout;
    assign ram_din = (ram_cs && ram_oe) ? mem[ram_addr] : '0;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    cmd_t cmdq0[$], cmdq1[$], expq0[$], expq1[$];
    cmd_t cur0, cur1, acc_cmd;
    int   gnt_order[$];
    bit   busy0 = 0, busy1 = 0;
    bit   prev_gnt0 = 0, prev_gnt1 = 0, prev_done0 = 0, prev_done1 = 0;
    int   vectors = 0, miscompares = 0, cyc = 0;
    int   gnt_cyc0 = 0, gnt_cyc1 = 0, last_gnt_cyc = -1, exp_gap = 0, since_gnt = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int who, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        cmd_t c;
        c = '{we: we, addr: a, data: d};
        if (who == 0) begin cmdq0.push_back(c); expq0.push_back(c); end
        else          begin cmdq1.push_back(c); expq1.push_back(c); end
    endtask

    task automatic kick();
        if (!busy0 && cmdq0.size() > 0) begin cur0 = cmdq0.pop_front(); busy0 = 1'b1; end
        if (!busy1 && cmdq1.size() > 0) begin cur1 = cmdq1.pop_front(); busy1 = 1'b1; end
        req0 = busy0; we0 = cur0.we; addr0 = cur0.addr; wdata0 = cur0.data;
        req1 = busy1; we1 = cur1.we; addr1 = cur1.addr; wdata1 = cur1.data;
    endtask

    // One clock: sample and check at negedge, then update requesters after the edge.
    task automatic tick();
        cmd_t e;
        @(negedge clk);
        cyc++;
        check("drive_oe_excl", ram_drive & ram_oe, 0);
        if (since_gnt >= 0) since_gnt++;
        if (since_gnt == 1) begin
            check("acc_cs", ram_cs, 1);
            check("acc_addr", ram_addr, acc_cmd.addr);
            check("acc_we", ram_we, acc_cmd.we);
            check("acc_oe", ram_oe, !acc_cmd.we);
            check("acc_drive", ram_drive, acc_cmd.we);
            if (acc_cmd.we) check("acc_dout", ram_dout, acc_cmd.data);
        end else if (since_gnt == 2 && !acc_cmd.we) begin
            check("cap_cs_oe_we_drv", {ram_cs, ram_oe, ram_we, ram_drive}, 4'b1100);
            check("cap_addr", ram_addr, acc_cmd.addr);
        end else begin
            check("idle_cs_drive", {ram_cs, ram_drive}, 2'b00);
        end
        if (done0) begin
            check("done0_pulse", prev_done0, 0);
            if (expq0.size() > 0) begin
                e = expq0.pop_front();
                check("done0_latency", cyc - gnt_cyc0, e.we ? 2 : 3);
                if (!e.we) check("rdata0", rdata, e.data);
            end else check("done0_unexpected", done0, 0);
        end
        if (done1) begin
            check("done1_pulse", prev_done1, 0);
            if (expq1.size() > 0) begin
                e = expq1.pop_front();
                check("done1_latency", cyc - gnt_cyc1, e.we ? 2 : 3);
                if (!e.we) check("rdata1", rdata, e.data);
            end else check("done1_unexpected", done1, 0);
        end
        if (gnt0 || gnt1) begin
            check("gnt_onehot", gnt0 & gnt1, 0);
            check("gnt_pulse", {gnt1 & prev_gnt1, gnt0 & prev_gnt0}, 0);
            check("gnt_needs_req", {gnt1 & ~req1, gnt0 & ~req0}, 0);
            if (gnt_order.size() > 0) check("gnt_order", gnt1 ? 1 : 0, gnt_order.pop_front());
            else check("gnt_unexpected", {gnt1, gnt0}, 0);
            if (exp_gap != 0 && last_gnt_cyc >= 0) check("gnt_gap", cyc - last_gnt_cyc, exp_gap);
            last_gnt_cyc = cyc;
            since_gnt = 0;
            if (gnt1) begin acc_cmd = cur1; gnt_cyc1 = cyc; busy1 = 1'b0; end
            else      begin acc_cmd = cur0; gnt_cyc0 = cyc; busy0 = 1'b0; end
        end
        prev_gnt0 = gnt0; prev_gnt1 = gnt1; prev_done0 = done0; prev_done1 = done1;
        @(posedge clk);
        #1;
        kick();
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        kick();
        while ((busy0 || busy1 || cmdq0.size() > 0 || cmdq1.size() > 0 ||
                expq0.size() > 0 || expq1.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_in_budget", n < budget, 1);
        check("gnt_order_drained", gnt_order.size(), 0);
        tick();
    endtask

    initial begin
        // Reset: outputs quiet even with a request pending.
        repeat (2) @(posedge clk);
        #1;
        req0 = 1'b1;
        #1;
        check("rst_gnt", {gnt1, gnt0}, 0);
        check("rst_done", {done1, done0}, 0);
        check("rst_ram", {ram_cs, ram_we, ram_oe, ram_drive}, 0);
        check("rst_addr_dout", {ram_addr, ram_dout}, 0);
        check("rst_rdata", rdata, 0);
        req0 = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Simultaneous writes: requester 0 first after reset, then 1 back-to-back.
        issue(0, 1'b1, 16'h7FFF, 8'h11);
        issue(1, 1'b1, 16'hBFFF, 8'h22);
        gnt_order.push_back(0); gnt_order.push_back(1);
        exp_gap = 2; last_gnt_cyc = -1;
        run_until_idle(50);
        exp_gap = 0;
        issue(0, 1'b0, 16'h7FFF, 8'h11);
        issue(1, 1'b0, 16'hBFFF, 8'h22);
        gnt_order.push_back(0); gnt_order.push_back(1);
        run_until_idle(50);

        // Lone write then read-back.
        issue(0, 1'b1, 16'h3FFC, 8'hA5);
        gnt_order.push_back(0);
        run_until_idle(50);
        issue(0, 1'b0, 16'h3FFC, 8'hA5);
        gnt_order.push_back(0);
        run_until_idle(50);

        // Leave the pointer favouring 0, then continuous reads from both.
        issue(1, 1'b0, 16'hBFFF, 8'h22);
        gnt_order.push_back(1);
        run_until_idle(50);
        exp_gap = 3; last_gnt_cyc = -1;
        for (int i = 0; i < 3; i++) begin
            issue(0, 1'b0, 16'h7FFF, 8'h11);
            issue(1, 1'b0, 16'hBFFF, 8'h22);
            gnt_order.push_back(0); gnt_order.push_back(1);
        end
        run_until_idle(100);
        exp_gap = 0;

        // Address extremes do not alias.
        issue(0, 1'b1, 16'hFFFF, 8'h5A);
        issue(1, 1'b1, 16'h0000, 8'h3C);
        gnt_order.push_back(0); gnt_order.push_back(1);
        run_until_idle(50);
        issue(0, 1'b0, 16'h0000, 8'h3C);
        issue(1, 1'b0, 16'hFFFF, 8'h5A);
        gnt_order.push_back(0); gnt_order.push_back(1);
        run_until_idle(50);

        // Reset while a read sits in CAPTURE.
        issue(0, 1'b0, 16'h0000, 8'h3C);
        gnt_order.push_back(0);
        kick();
        for (int n = 0; n < 20 && busy0; n++) tick();
        check("abort_grant_seen", busy0, 0);
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_ram", {ram_cs, ram_we, ram_oe, ram_drive}, 0);
        check("abort_gnt_done", {gnt1, gnt0, done1, done0}, 0);
        check("abort_rdata", rdata, 0);
        void'(expq0.pop_front());
        since_gnt = -1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        issue(0, 1'b0, 16'h0000, 8'h3C);
        gnt_order.push_back(0);
        run_until_idle(50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, RAM data width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req0/req1  input  1  access request from requester 0/1.
REQ-006 SHALL have ports we0/we1  input  1  request type per requester: 1 = write, 0 = read.
REQ-007 SHALL have ports addr0/addr1  input  ADDR_WIDTH  request address per requester.
REQ-008 SHALL have ports wdata0/wdata1  input  DATA_WIDTH  write data per requester.
REQ-009 SHALL have ports gnt0/gnt1  output  1  one-cycle grant pulse per requester.
REQ-010 SHALL have ports done0/done1  output  1  one-cycle completion pulse per requester.
REQ-011 SHALL have port rdata  output  DATA_WIDTH  read result, valid while done0/done1 is high for a read.
REQ-012 SHALL have ports ram_cs, ram_we, ram_oe  output  1  each; RAM chip select, write enable and output enable.
REQ-013 SHALL have port ram_addr  output  ADDR_WIDTH  RAM address.
REQ-014 SHALL have ports ram_dout  output  DATA_WIDTH  and ram_drive  output  1: write data, plus the enable for the top-level tristate onto the RAM data bus.
REQ-015 SHALL have port ram_din  input  DATA_WIDTH  sampled RAM data bus.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, CAPTURE.
REQ-017 In IDLE with any req high, SHALL latch the winner's we/addr/wdata, pulse the winner's gnt for exactly one cycle, and move to ACCESS.
REQ-018 SHALL arbitrate round-robin: a lone requester wins; when both request, the requester not granted last wins; after reset, requester 0 has priority.
REQ-019 Requesters SHALL hold req/we/addr/wdata stable until gnt; the arbiter SHALL ignore command inputs outside the grant edge.
REQ-020 In ACCESS, SHALL drive ram_cs=1, ram_addr=latched addr, ram_we=latched we, and ram_oe=!latched we; on a write it SHALL also drive ram_drive=1 and ram_dout=latched wdata.
REQ-021 Write path: ACCESS -> IDLE; the owner's done SHALL pulse in the cycle after ACCESS.
REQ-022 Read path: ACCESS -> CAPTURE; in CAPTURE it SHALL hold ram_cs=1, ram_oe=1, ram_we=0, ram_drive=0 and register ram_din into rdata at the end of CAPTURE.
REQ-023 After CAPTURE, SHALL return to IDLE and pulse the owner's done with rdata valid; rdata SHALL hold until the next read completes.
REQ-024 Latency from the grant edge: write done SHALL pulse 2 cycles after gnt; read done SHALL pulse 3 cycles after gnt.
REQ-025 ram_drive and ram_oe SHALL never be high in the same cycle; ram_drive SHALL be 0 in every state other than a write ACCESS.
REQ-026 A req that arrives while not in IDLE SHALL wait; a grant SHALL be issued in the same IDLE cycle in which done pulses (back-to-back throughput: write every 2 cycles, read every 3 cycles).
REQ-027 Address handling SHALL pass the full range 0..2**ADDR_WIDTH-1 unchanged, with no wrap or translation.

Reset
REQ-028 On rst_n low, SHALL asynchronously force IDLE, all gnt/done/ram_* outputs to 0, rdata to 0, and the round-robin pointer to favour requester 0.
REQ-029 Reset mid-operation SHALL discard the in-flight command with no done pulse; after release, the first request SHALL be re-arbitrated from IDLE.

Structure
REQ-030 A shared package ram_ctrl_pkg SHALL hold the FSM state typedef and the default ADDR_WIDTH/DATA_WIDTH constants.
REQ-031 The arbitration decision SHALL be a sub-module rr_arb2 (2-way round-robin with a registered last-grant pointer); no other sub-modules.

Verification
REQ-032 Write 0xA5 to 0x3FFC from requester 0, then read it back -> gnt0 pulses, done0 two cycles later; read done0 three cycles after gnt with rdata=0xA5.
REQ-033 req0 and req1 high together, both writing (0x7FFF, 0x11) and (0xBFFF, 0x22) -> gnt0 first, then gnt1 in the IDLE cycle where done0 pulses; both locations read back correctly.
REQ-034 Both requesters issue continuous reads -> grants alternate 0,1,0,1 with one grant every 3 cycles.
REQ-035 Write 0x5A to 0xFFFF and 0x3C to 0x0000 -> both read back exactly, with no alias.
REQ-036 rst_n low during the CAPTURE of a read -> all outputs 0 immediately, no done pulse; a read after release returns the stored value.
REQ-037 An assertion over all scenarios SHALL check that ram_drive and ram_oe are never both 1 and that gnt/done are one-cycle pulses.
